// File: rtl/ha_sub_core.sv
// Registered multi-lane half subtractor: per-lane difference and borrow,
// an any-borrow flag and a saturating borrow-event counter.
module ha_sub_core #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] bw,
  output logic             out_valid,
  output logic             bw_any,
  output logic [CNT_W-1:0] bw_cnt
);

  logic [WIDTH-1:0] d_nxt;
  logic [WIDTH-1:0] bw_nxt;
  logic             bw_any_nxt;
  logic             cnt_sat;

  // Lanes are independent: no borrow ripples from lane i into lane i+1.
  always_comb begin
    d_nxt      = a ^ b;
    bw_nxt     = ~a & b;
    bw_any_nxt = |bw_nxt;
    cnt_sat    = &bw_cnt;
  end

  // Datapath only loads on accepted samples, so X on a/b while idle is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d         <= '0;
      bw        <= '0;
      out_valid <= 1'b0;
      bw_any    <= 1'b0;
      bw_cnt    <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        d      <= d_nxt;
        bw     <= bw_nxt;
        bw_any <= bw_any_nxt;
        if (bw_any_nxt && !cnt_sat) begin
          bw_cnt <= bw_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ha_sub_core.sv
// Self-checking bench for ha_sub_core: a 4-lane/2-bit-counter instance and a
// 1-lane/8-bit-counter instance driven together and compared to a reference model.
module tb_ha_sub_core;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;

  logic [3:0] u4_d, u4_bw;
  logic       u4_ov, u4_any;
  logic [1:0] u4_cnt;
  logic [0:0] u1_d, u1_bw;
  logic       u1_ov, u1_any;
  logic [7:0] u1_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [3:0] m4_d, m4_bw;
  logic       m4_any, m_ov;
  int         m4_cnt;
  logic       m1_d, m1_bw, m1_any;
  int         m1_cnt;

  logic [11:0] obs4, obs1;
  assign obs4 = {u4_d, u4_bw, u4_any, u4_ov, u4_cnt};
  assign obs1 = {u1_d, u1_bw, u1_any, u1_ov, u1_cnt};

  ha_sub_core #(.WIDTH(4), .CNT_W(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .d(u4_d), .bw(u4_bw), .out_valid(u4_ov), .bw_any(u4_any), .bw_cnt(u4_cnt)
  );

  ha_sub_core #(.WIDTH(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[0:0]), .b(b[0:0]),
    .d(u1_d), .bw(u1_bw), .out_valid(u1_ov), .bw_any(u1_any), .bw_cnt(u1_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] exp4();
    return {m4_d, m4_bw, m4_any, m_ov, 2'(m4_cnt)};
  endfunction

  function automatic logic [11:0] exp1();
    return {m1_d, m1_bw, m1_any, m_ov, 8'(m1_cnt)};
  endfunction

  // Drive one cycle, advance the model over the edge, settle for sampling.
  task automatic drive(input logic [3:0] av, input logic [3:0] bv,
                       input logic v, input logic r);
    int diff;
    @(negedge clk);
    a = av; b = bv; in_valid = v; rst_n = r;
    @(posedge clk);
    if (!r) begin
      m4_d = '0; m4_bw = '0; m4_any = 0; m_ov = 0; m4_cnt = 0;
      m1_d = 0; m1_bw = 0; m1_any = 0; m1_cnt = 0;
    end else if (v) begin
      for (int i = 0; i < 4; i++) begin
        diff     = int'(av[i]) - int'(bv[i]);
        m4_d[i]  = (diff != 0);
        m4_bw[i] = (diff < 0);
      end
      m4_any = (m4_bw != 4'd0);
      m1_d   = m4_d[0];
      m1_bw  = m4_bw[0];
      m1_any = m1_bw;
      m_ov   = 1'b1;
      if (m4_any && m4_cnt < 3)   m4_cnt = m4_cnt + 1;
      if (m1_any && m1_cnt < 255) m1_cnt = m1_cnt + 1;
    end else begin
      m_ov = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(4'hF, 4'hF, 1'b1, 1'b0);
      n_checks++;
      if (obs4 !== 12'h000) begin
        n_fail++; $display("FAIL reset_w4 cyc%0d: got %h, want 000", k, obs4);
      end
      n_checks++;
      if (obs1 !== 12'h000) begin
        n_fail++; $display("FAIL reset_w1 cyc%0d: got %h, want 000", k, obs1);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [3:0] a_seq, b_seq, d_tab, bw_tab;
    a_seq = 4'b1100; b_seq = 4'b1010; d_tab = 4'b0110; bw_tab = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      drive({4{a_seq[k]}}, {4{b_seq[k]}}, 1'b1, 1'b1);
      n_checks++;
      if ({u1_d, u1_bw, u1_ov} !== {d_tab[k], bw_tab[k], 1'b1}) begin
        n_fail++;
        $display("FAIL exhaustive ab=%b%b: got d,bw,ov=%b%b%b, want %b%b1",
                 a_seq[k], b_seq[k], u1_d, u1_bw, u1_ov, d_tab[k], bw_tab[k]);
      end
      n_checks++;
      if (obs4 !== exp4()) begin
        n_fail++; $display("FAIL exhaustive_w4 k=%0d: got %h, want %h", k, obs4, exp4());
      end
    end
    n_checks++;
    if (u1_cnt !== 8'd1) begin
      n_fail++; $display("FAIL exhaustive_cnt: got %0d, want 1", u1_cnt);
    end
  endtask

  task automatic test_hold();
    logic [7:0] cnt_before;
    drive(4'b0000, 4'b1111, 1'b1, 1'b1);
    cnt_before = u1_cnt;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) drive(4'bxxxx, 4'bxxxx, 1'b0, 1'b1);
      else        drive(4'($urandom), 4'($urandom), 1'b0, 1'b1);
      n_checks++;
      if ({u1_d, u1_bw, u1_ov} !== 3'b110 || u1_cnt !== cnt_before) begin
        n_fail++;
        $display("FAIL hold k=%0d: got d,bw,ov=%b%b%b cnt=%0d, want 110 cnt=%0d",
                 k, u1_d, u1_bw, u1_ov, u1_cnt, cnt_before);
      end
      n_checks++;
      if (obs4 !== exp4()) begin
        n_fail++; $display("FAIL hold_w4 k=%0d: got %h, want %h", k, obs4, exp4());
      end
    end
  endtask

  task automatic test_multi_lane();
    drive(4'b1010, 4'b0110, 1'b1, 1'b1);
    n_checks++;
    if ({u4_d, u4_bw, u4_any, u4_ov} !== {4'b1100, 4'b0100, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL multi_lane: got d=%b bw=%b any=%b ov=%b, want d=1100 bw=0100 any=1 ov=1",
               u4_d, u4_bw, u4_any, u4_ov);
    end
  endtask

  task automatic test_saturation();
    int want;
    drive(4'h0, 4'h0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(4'b0000, 4'b0001, 1'b1, 1'b1);
      want = (k + 1 > 3) ? 3 : k + 1;
      n_checks++;
      if (u4_cnt !== 2'(want)) begin
        n_fail++; $display("FAIL saturation k=%0d: got %0d, want %0d", k, u4_cnt, want);
      end
      n_checks++;
      if (u1_cnt !== 8'(k + 1)) begin
        n_fail++; $display("FAIL sat_w1_cnt k=%0d: got %0d, want %0d", k, u1_cnt, k + 1);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(4'h0, 4'h0, 1'b1, 1'b0);
    drive(4'b0000, 4'b0001, 1'b1, 1'b1);
    drive(4'b0000, 4'b0001, 1'b1, 1'b1);
    n_checks++;
    if (u4_cnt !== 2'd2) begin
      n_fail++; $display("FAIL midrst_pre: got %0d, want 2", u4_cnt);
    end
    drive(4'b0000, 4'b0001, 1'b1, 1'b0);
    n_checks++;
    if (obs4 !== 12'h000 || obs1 !== 12'h000) begin
      n_fail++; $display("FAIL midrst_edge: got %h/%h, want 000/000", obs4, obs1);
    end
    drive(4'b0000, 4'b0001, 1'b1, 1'b1);
    n_checks++;
    if (u4_cnt !== 2'd1 || u1_cnt !== 8'd1 || u4_ov !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_after: got cnt4=%0d cnt1=%0d ov=%b, want 1 1 1",
               u4_cnt, u1_cnt, u4_ov);
    end
  endtask

  task automatic test_random();
    logic v, r;
    for (int k = 0; k < 300; k++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 31) != 0);
      if (v) drive(4'($urandom), 4'($urandom), v, r);
      else   drive(4'bxxxx, 4'bxxxx, v, r);
      n_checks++;
      if (obs4 !== exp4()) begin
        n_fail++; $display("FAIL random_w4 k=%0d: got %h, want %h", k, obs4, exp4());
      end
      n_checks++;
      if (obs1 !== exp1()) begin
        n_fail++; $display("FAIL random_w1 k=%0d: got %h, want %h", k, obs1, exp1());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    m4_d = '0; m4_bw = '0; m4_any = 0; m_ov = 0; m4_cnt = 0;
    m1_d = 0; m1_bw = 0; m1_any = 0; m1_cnt = 0;
    test_reset();
    test_exhaustive();
    test_hold();
    test_multi_lane();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
